// File: rtl/universal_shift_engine_pkg.sv
// Shared definitions for the universal shift engine.
//   mode_e  : IDLE-state operation codes (HOLD..FRAME)
//   state_e : two-state control FSM encoding
//   beats_f : number of serial beats needed to move WIDTH bits over LANES
package universal_shift_engine_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ROL   = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_FRAME = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TX   = 1'b1
  } state_e;

  function automatic int beats_f(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/shift_beat_counter.sv
// Frame beat counter.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (start of a frame)
//   load_val  : beats in the frame
//   accept    : a beat was accepted this cycle, decrement
//   last      : the beat currently presented is the final one
module shift_beat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             accept,
  output logic             last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (accept && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/universal_shift_engine.sv
// Universal shift register with an IDLE command set (hold, shifts, rotates,
// load) and a FRAME command that serialises the register LANES bits per beat
// over a valid/ready output.
//   clk, rst     : clock, synchronous active-high reset
//   mode         : operation code (mode_e), sampled in IDLE only
//   msb_first    : frame bit order, captured with FRAME
//   s_in         : serial input lane
//   p_in         : parallel load data
//   s_out_ready  : downstream accepts the presented beat
//   p_out        : register contents
//   s_out        : serial output lane (last shifted-out lanes in IDLE)
//   s_out_valid  : frame beat valid
//   busy         : frame in progress
//   done         : one-cycle pulse after the final frame beat
//   parity       : XOR of p_out (only with SHIFT_ENGINE_PARITY_EN)
// Build option: SHIFT_ENGINE_PARITY_EN adds the parity port and appends an
// even-parity beat to every frame.
module universal_shift_engine
  import universal_shift_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             msb_first,
  input  logic [LANES-1:0] s_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic             s_out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic [LANES-1:0] s_out,
  output logic             s_out_valid,
  output logic             busy,
  output logic             done
`ifdef SHIFT_ENGINE_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int BEATS = beats_f(WIDTH, LANES);
`ifdef SHIFT_ENGINE_PARITY_EN
  localparam int FRAME_BEATS = BEATS + 1;
`else
  localparam int FRAME_BEATS = BEATS;
`endif
  localparam int CNT_W = $clog2(BEATS + 2);

  if (WIDTH < 2 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_cfg
    $error("universal_shift_engine: WIDTH must be >= 2 and a multiple of LANES");
  end

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        p_q, p_d;
  logic signed [WIDTH-1:0] p_sgn;
  logic [LANES-1:0]        s_last_q, s_last_d;
  logic [LANES-1:0]        tx_beat;
  logic                    msb_q, msb_d;
  logic                    done_d;
  logic                    accept;
  logic                    cnt_load;
  logic                    cnt_last;
  mode_e                   mode_cmd;
`ifdef SHIFT_ENGINE_PARITY_EN
  logic                    frame_par_q, frame_par_d;
`endif

  assign mode_cmd = mode_e'(mode);
  assign p_sgn    = p_q;
  assign accept   = (state_q == ST_TX) && s_out_ready;
  assign cnt_load = (state_q == ST_IDLE) && (mode_cmd == MODE_FRAME);

  shift_beat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(FRAME_BEATS)),
    .accept   (accept),
    .last     (cnt_last)
  );

  // Beat presented during TX, taken straight from the register end.
  always_comb begin
    tx_beat = msb_q ? p_q[WIDTH-1:WIDTH-LANES] : p_q[LANES-1:0];
`ifdef SHIFT_ENGINE_PARITY_EN
    // The extra final beat carries the frame parity on lane 0.
    if (cnt_last) tx_beat = LANES'(frame_par_q);
`endif
  end

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    s_last_d    = s_last_q;
    msb_d       = msb_q;
    done_d      = 1'b0;
    busy        = 1'b0;
    s_out_valid = 1'b0;
    s_out       = s_last_q;
`ifdef SHIFT_ENGINE_PARITY_EN
    frame_par_d = frame_par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        case (mode_cmd)
          MODE_HOLD: ;
          MODE_SHR: begin
            p_d      = WIDTH'({s_in, p_q} >> LANES);
            s_last_d = p_q[LANES-1:0];
          end
          MODE_SHL: begin
            p_d      = WIDTH'({p_q, s_in});
            s_last_d = p_q[WIDTH-1:WIDTH-LANES];
          end
          MODE_LOAD: p_d = p_in;
          MODE_ROR: begin
            p_d      = WIDTH'({p_q, p_q} >> LANES);
            s_last_d = p_q[LANES-1:0];
          end
          MODE_ROL: begin
            p_d      = WIDTH'({p_q, p_q} >> (WIDTH - LANES));
            s_last_d = p_q[WIDTH-1:WIDTH-LANES];
          end
          MODE_ASR: begin
            p_d      = p_sgn >>> LANES;
            s_last_d = p_q[LANES-1:0];
          end
          MODE_FRAME: begin
            p_d     = p_in;
            msb_d   = msb_first;
            state_d = ST_TX;
`ifdef SHIFT_ENGINE_PARITY_EN
            frame_par_d = ^p_in;
`endif
          end
          default: ;
        endcase
      end
      ST_TX: begin
        busy        = 1'b1;
        s_out_valid = 1'b1;
        s_out       = tx_beat;
        if (s_out_ready) begin
          p_d = msb_q ? (p_q << LANES) : (p_q >> LANES);
          if (cnt_last) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            s_last_d = tx_beat;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      p_q      <= '0;
      s_last_q <= '0;
      msb_q    <= 1'b0;
      done     <= 1'b0;
`ifdef SHIFT_ENGINE_PARITY_EN
      frame_par_q <= 1'b0;
      parity      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      s_last_q <= s_last_d;
      msb_q    <= msb_d;
      done     <= done_d;
`ifdef SHIFT_ENGINE_PARITY_EN
      frame_par_q <= frame_par_d;
      parity      <= ^p_d;
`endif
    end
  end

  assign p_out = p_q;

endmodule

// File: tb/tb_universal_shift_engine.sv
// Testbench for universal_shift_engine: three instances (LANES = 2, 1, 8 at
// WIDTH = 8). Frame beats are checked by a scoreboard queue against a
// behavioural model; IDLE operations are checked against the same model.
module tb_universal_shift_engine;
  import universal_shift_engine_pkg::*;

  localparam int W  = 8;
  localparam int LA = 2;
  localparam int LB = 1;
  localparam int LC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: LANES = 2
  logic [2:0]    mode_a;
  logic          msb_a, rdy_a;
  logic [LA-1:0] sin_a, sout_a;
  logic [W-1:0]  pin_a, pout_a;
  logic          vld_a, busy_a, done_a;
`ifdef SHIFT_ENGINE_PARITY_EN
  logic          par_a;
`endif

  universal_shift_engine #(.WIDTH(W), .LANES(LA)) u_a (
    .clk(clk), .rst(rst), .mode(mode_a), .msb_first(msb_a), .s_in(sin_a),
    .p_in(pin_a), .s_out_ready(rdy_a), .p_out(pout_a), .s_out(sout_a),
    .s_out_valid(vld_a), .busy(busy_a), .done(done_a)
`ifdef SHIFT_ENGINE_PARITY_EN
    , .parity(par_a)
`endif
  );

  // Instance B: LANES = 1
  logic [2:0]    mode_b;
  logic          msb_b, rdy_b;
  logic [LB-1:0] sin_b, sout_b;
  logic [W-1:0]  pin_b, pout_b;
  logic          vld_b, busy_b, done_b;
`ifdef SHIFT_ENGINE_PARITY_EN
  logic          par_b;
`endif

  universal_shift_engine #(.WIDTH(W), .LANES(LB)) u_b (
    .clk(clk), .rst(rst), .mode(mode_b), .msb_first(msb_b), .s_in(sin_b),
    .p_in(pin_b), .s_out_ready(rdy_b), .p_out(pout_b), .s_out(sout_b),
    .s_out_valid(vld_b), .busy(busy_b), .done(done_b)
`ifdef SHIFT_ENGINE_PARITY_EN
    , .parity(par_b)
`endif
  );

  // Instance C: LANES = WIDTH
  logic [2:0]    mode_c;
  logic          msb_c, rdy_c;
  logic [LC-1:0] sin_c, sout_c;
  logic [W-1:0]  pin_c, pout_c;
  logic          vld_c, busy_c, done_c;
`ifdef SHIFT_ENGINE_PARITY_EN
  logic          par_c;
`endif

  universal_shift_engine #(.WIDTH(W), .LANES(LC)) u_c (
    .clk(clk), .rst(rst), .mode(mode_c), .msb_first(msb_c), .s_in(sin_c),
    .p_in(pin_c), .s_out_ready(rdy_c), .p_out(pout_c), .s_out(sout_c),
    .s_out_valid(vld_c), .busy(busy_c), .done(done_c)
`ifdef SHIFT_ENGINE_PARITY_EN
    , .parity(par_c)
`endif
  );

  // Reference model state for instance A
  int m_reg, m_last;
  int exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural IDLE-mode model written as integer arithmetic.
  function automatic void model_op(input int md, input int sin, input int pin);
    int mask = (1 << W) - 1;
    int lm   = (1 << LA) - 1;
    int r    = m_reg;
    case (md)
      1: begin m_reg = (r >> LA) | (sin << (W - LA));           m_last = r & lm; end
      2: begin m_reg = ((r << LA) | sin) & mask;                m_last = r >> (W - LA); end
      3: m_reg = pin;
      4: begin m_reg = ((r >> LA) | (r << (W - LA))) & mask;    m_last = r & lm; end
      5: begin m_reg = ((r << LA) | (r >> (W - LA))) & mask;    m_last = r >> (W - LA); end
      6: begin m_reg = (r >> LA) | ((((r >> (W - 1)) & 1) != 0) ? (lm << (W - LA)) : 0);
               m_last = r & lm; end
      default: ;
    endcase
  endfunction

  task automatic op_a(input int md, input int sin, input int pin);
    mode_a = md[2:0];
    sin_a  = sin[LA-1:0];
    pin_a  = pin[W-1:0];
    msb_a  = 1'($urandom);
    @(posedge clk); #1;
    model_op(md, sin, pin);
    chk("idle_p_out", pout_a, m_reg);
    chk("idle_s_out", sout_a, m_last);
    chk("idle_busy", {busy_a, vld_a}, 0);
`ifdef SHIFT_ENGINE_PARITY_EN
    chk("parity_port", par_a, ^m_reg[W-1:0]);
`endif
    mode_a = 3'(MODE_HOLD);
  endtask

  // Issue a FRAME on A. stall_at/stall_len force ready low on one beat;
  // rst_at asserts reset while that beat is presented (-1 disables).
  task automatic frame_a(input int data, input bit msb, input int stall_at,
                         input int stall_len, input int rst_at, input bit rand_rdy);
    int lm = (1 << LA) - 1;
    int fb = W / LA;
    int acc = 0, stalls = 0, cyc = 0, last_beat = 0, b;
    for (int k = 0; k < W / LA; k++) begin
      b = msb ? ((data >> (W - LA - k * LA)) & lm) : ((data >> (k * LA)) & lm);
      exp_q.push_back(b);
      last_beat = b;
    end
`ifdef SHIFT_ENGINE_PARITY_EN
    last_beat = ^data[W-1:0];
    exp_q.push_back(last_beat);
    fb++;
`endif
    mode_a = 3'(MODE_FRAME); pin_a = data[W-1:0]; msb_a = msb; rdy_a = 1'b1;
    @(posedge clk); #1;
    chk("frame_busy", busy_a, 1);
    chk("frame_load", pout_a, data);
    while (acc < fb) begin
      if (cyc++ > 200) begin
        chk("frame_timeout", acc, fb);
        break;
      end
      // Commands while busy must be ignored, including a competing FRAME.
      mode_a = 3'($urandom_range(0, 7)); msb_a = 1'($urandom);
      pin_a = W'($urandom); sin_a = LA'($urandom);
      if (acc == rst_at) begin
        rdy_a = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", busy_a, 0);
        chk("rst_p_out", pout_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_s_out", sout_a, 0);
        exp_q.delete();
        m_reg = 0; m_last = 0;
        mode_a = 3'(MODE_HOLD);
        @(posedge clk); #1;
        chk("rst_no_done", done_a, 0);
        return;
      end
      if (acc == stall_at && stalls < stall_len) begin
        rdy_a = 1'b0; stalls++;
      end else begin
        rdy_a = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(posedge clk); #1;
      if (rdy_a) acc++;
      if (acc < fb) begin
        chk("tx_busy", busy_a, 1);
        chk("tx_no_done", done_a, 0);
      end
    end
    mode_a = 3'(MODE_HOLD); rdy_a = 1'b0;
    chk("end_busy", busy_a, 0);
    chk("end_done", done_a, 1);
    chk("end_p_out", pout_a, 0);
    chk("end_s_last", sout_a, last_beat);
    m_reg = 0; m_last = last_beat;
    @(posedge clk); #1;
    chk("done_one_cycle", done_a, 0);
  endtask

  // Scoreboard monitor: compares every presented beat, pops on acceptance.
  always @(negedge clk) begin
    if (!rst && vld_a === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", vld_a, 0);
      end else begin
        chk("beat", sout_a, exp_q[0]);
        if (rdy_a) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int cpar;
    rst = 1'b1;
    mode_a = '0; msb_a = 0; sin_a = '0; pin_a = '0; rdy_a = 0;
    mode_b = '0; msb_b = 0; sin_b = '0; pin_b = '0; rdy_b = 0;
    mode_c = '0; msb_c = 0; sin_c = '0; pin_c = '0; rdy_c = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_p_out", pout_a, 0);
    chk("reset_s_out", sout_a, 0);
    chk("reset_ctrl", {busy_a, vld_a, done_a}, 0);
    rst = 1'b0;
    m_reg = 0; m_last = 0;

    // LANES=2: LOAD 0x81, ASR -> 0xE0, ROL -> 0x83
    op_a(3, 0, 'h81);
    op_a(6, 0, 0);
    chk("asr_fill", pout_a, 'hE0);
    op_a(5, 0, 0);
    chk("rol_wrap", pout_a, 'h83);

    // 0xB4 LSB-first: beats 0,1,3,2
    frame_a('hB4, 0, -1, 0, -1, 0);
    // Same frame with a three-cycle stall on the third beat
    frame_a('hB4, 0, 2, 3, -1, 0);
    frame_a('hB4, 1, -1, 0, -1, 1);

    for (int i = 0; i < 60; i++) begin
      if (i % 15 == 7)
        frame_a(int'($urandom_range(0, 255)), 1'($urandom), -1, 0, -1, 1);
      else
        op_a(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    end

    // Reset while the third beat is presented
    frame_a('hB4, 0, -1, 0, 2, 0);
    op_a(3, 0, 'h3C);

    // LANES=1: LOAD 0xA5, SHR with s_in=1 -> 0xD2, s_out=1
    mode_b = 3'(MODE_LOAD); pin_b = 8'hA5;
    @(posedge clk); #1;
    mode_b = 3'(MODE_SHR); sin_b = 1'b1;
    @(posedge clk); #1;
    mode_b = 3'(MODE_HOLD);
    chk("shr_p_out", pout_b, 'hD2);
    chk("shr_s_out", sout_b, 1);

    // LANES=WIDTH: a frame is a single data beat
    mode_c = 3'(MODE_FRAME); pin_c = 8'h5A; msb_c = 1'($urandom); rdy_c = 1'b1;
    @(posedge clk); #1;
    mode_c = 3'(MODE_HOLD);
    chk("one_beat_valid", {busy_c, vld_c}, 2'b11);
    chk("one_beat_data", sout_c, 'h5A);
    cpar = 'h5A;
`ifdef SHIFT_ENGINE_PARITY_EN
    @(posedge clk); #1;
    chk("one_beat_par_valid", vld_c, 1);
    cpar = 0;
`endif
    @(posedge clk); #1;
    chk("one_beat_done", {busy_c, done_c}, 2'b01);
    chk("one_beat_s_last", sout_c, cpar);
    rdy_c = 1'b0;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_shift_engine.md
UNIVERSAL_SHIFT_ENGINE -- requirements
Module: universal_shift_engine

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; minimum 2.
REQ-002 Parameter LANES, default 1: serial lane width in bits; WIDTH % LANES SHALL be 0; BEATS = WIDTH/LANES.
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port mode, input, 3: operation select, sampled only in IDLE.
REQ-006 Port msb_first, input, 1: frame bit order, sampled with the FRAME command.
REQ-007 Port s_in, input, LANES: serial input lane.
REQ-008 Port p_in, input, WIDTH: parallel load data.
REQ-009 Port s_out_ready, input, 1: downstream accepts the current frame beat.
REQ-010 Port p_out, output, WIDTH: register contents.
REQ-011 Port s_out, output, LANES: serial output lane.
REQ-012 Port s_out_valid, output, 1: s_out carries a valid frame beat.
REQ-013 Port busy, output, 1: high while in TX state.
REQ-014 Port done, output, 1: one-cycle pulse at frame completion.

Function
REQ-015 FSM states: IDLE and TX.
REQ-016 In IDLE, mode codes: 000 HOLD; 001 SHR, p_out <= {s_in, p_out[W-1:L]}; 010 SHL, p_out <= {p_out[W-L-1:0], s_in}; 011 LOAD, p_out <= p_in; 100 ROR by LANES; 101 ROL by LANES; 110 ASR, vacated lanes filled with p_out[W-1]; 111 FRAME.
REQ-017 SHR/ASR/ROR SHALL register the lanes leaving bit 0 into s_last, and SHL/ROL SHALL register the lanes leaving bit W-1; HOLD and LOAD leave s_last unchanged.
REQ-018 In IDLE, s_out = s_last, s_out_valid = 0, busy = 0.
REQ-019 FRAME: p_out <= p_in, latch msb_first, beat counter <= BEATS, next state TX; effect is visible on the following cycle.
REQ-020 In TX: s_out_valid = 1; s_out = p_out[L-1:0] for LSB-first, p_out[W-1:W-L] for MSB-first, combinational from the register.
REQ-021 A beat is accepted when s_out_valid and s_out_ready are both 1; on acceptance the register shifts by LANES toward the output end, zero-filled, and the counter decrements.
REQ-022 s_out_ready low SHALL stall TX with register, counter and s_out stable.
REQ-023 Acceptance of the last beat (counter == 1) SHALL return to IDLE, pulse done for the next cycle only, and load s_last with the final beat.
REQ-024 mode and msb_first SHALL be ignored while busy; FRAME is not queued.
REQ-025 When LANES == WIDTH, a frame is exactly one beat.
REQ-026 Counter width SHALL be $clog2(BEATS+2) bits (covers the parity beat); no wrap below 1 in TX.

Reset
REQ-027 rst high SHALL force IDLE, p_out = 0, s_last = 0, counter = 0, done = 0, parity = 0 on the next edge; this overrides any operation in progress.
REQ-028 Reset in mid-frame SHALL abort the frame without a done pulse.

Configuration
REQ-029 With SHIFT_ENGINE_PARITY_EN defined: add output parity, width 1, equal to the registered XOR of p_out; FRAME SHALL append one extra beat after the data beats, carrying even parity of the loaded frame on s_out[0] with the other lanes at 0; done follows that beat.
REQ-030 Without SHIFT_ENGINE_PARITY_EN: no parity port, frames are exactly BEATS beats.

Structure
REQ-031 A shared package SHALL hold the mode enum (HOLD..FRAME codes), the FSM state typedef, and a BEATS helper function.
REQ-032 One sub-module, shift_beat_counter (load, decrement-on-accept, last flag), is natural; all else stays in the top.

Verification
REQ-033 WIDTH=8, LANES=1: LOAD 0xA5, then SHR with s_in=1 -> p_out=0xD2, s_out=1.
REQ-034 WIDTH=8, LANES=2: LOAD 0x81, then ASR -> p_out=0xE0; then ROL -> p_out=0x83.
REQ-035 WIDTH=8, LANES=2: FRAME p_in=0xB4, LSB-first, ready held high -> s_out beats 0,1,3,2, then done pulses once and busy drops.
REQ-036 Same frame with ready low for 3 cycles on beat 2 -> s_out holds 3 for all stalled cycles; the beat sequence is unchanged.
REQ-037 rst asserted on beat 3 of a frame -> next cycle IDLE, p_out=0, no done pulse; a FRAME command issued during busy is ignored.
REQ-038 With SHIFT_ENGINE_PARITY_EN, FRAME 0x07 (WIDTH=8, LANES=4) -> beats 7, 0, then parity beat 1; done follows the third beat.
